// File: rtl/shift_mult_if.sv
// Multiplier mutex bundle shared by compute engines and the shift-add server.
// Engines drive the master side; the server is the slave.
interface shift_mult_if #(
  parameter int NumClients = 4,
  parameter int DataWidth  = 8
);
  logic [NumClients-1:0]           req_i;
  logic [NumClients-1:0]           grant_o;
  logic [NumClients-1:0]           start_i;
  logic [NumClients*DataWidth-1:0] a_i;
  logic [NumClients*DataWidth-1:0] b_i;
  logic                            busy_o;
  logic [NumClients-1:0]           done_o;
  logic [2*DataWidth-1:0]          result_o;

  modport slave (
    input  req_i,
    input  start_i,
    input  a_i,
    input  b_i,
    output grant_o,
    output busy_o,
    output done_o,
    output result_o
  );

  modport master (
    output req_i,
    output start_i,
    output a_i,
    output b_i,
    input  grant_o,
    input  busy_o,
    input  done_o,
    input  result_o
  );
endinterface

// File: rtl/shift_mult_server.sv
// Round-robin shared shift-add multiplier, one product bit per cycle.
// SHIFT_MULT_SIGNED_EN selects two's complement operands.
module shift_mult_server #(
  parameter int NumClients     = 4,
  parameter int DataWidth      = 8,
  parameter int ClientIdxWidth =
    (NumClients > 1) ? $clog2(NumClients) : 1
) (
  input logic         clk_i,
  input logic         reset_ni,
  shift_mult_if.slave bus
);

  localparam int ProdW = 2 * DataWidth;
  localparam int CntW  = $clog2(DataWidth + 1);
`ifdef SHIFT_MULT_SIGNED_EN
  localparam int MplW  = DataWidth + 1;
`else
  localparam int MplW  = DataWidth;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_CALC,
    ST_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [NumClients-1:0]     grant_q, grant_d;
  logic [NumClients-1:0]     done_q, done_d;
  logic [ProdW-1:0]          result_q, result_d;
  logic [ClientIdxWidth-1:0] rr_q, rr_d;
  logic [ProdW-1:0]          acc_q, acc_d;
  logic [ProdW-1:0]          mcand_q, mcand_d;
  logic [MplW-1:0]           mplier_q, mplier_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
`ifdef SHIFT_MULT_SIGNED_EN
  logic                      neg_q, neg_d;
`endif

  logic                      pick_valid;
  logic [ClientIdxWidth-1:0] pick_idx;
  logic [ClientIdxWidth-1:0] cand;
  logic                      req_g;
  logic                      start_g;
  logic [DataWidth-1:0]      a_sel;
  logic [DataWidth-1:0]      b_sel;
  logic [ProdW-1:0]          mcand_init;
  logic [MplW-1:0]           mplier_init;
  logic [ProdW-1:0]          product;

  // Walk downward so the client nearest rr+1 is written last and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NumClients; i >= 1; i--) begin
      cand = ClientIdxWidth'((int'(rr_q) + i) % NumClients);
      if (bus.req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // rr_q doubles as the granted client index once a grant is out.
  always_comb begin
    req_g   = 1'b0;
    start_g = 1'b0;
    a_sel   = '0;
    b_sel   = '0;
    for (int k = 0; k < NumClients; k++) begin
      if (rr_q == ClientIdxWidth'(k)) begin
        req_g   = bus.req_i[k];
        start_g = bus.start_i[k];
        a_sel   = bus.a_i[k*DataWidth +: DataWidth];
        b_sel   = bus.b_i[k*DataWidth +: DataWidth];
      end
    end
  end

`ifdef SHIFT_MULT_SIGNED_EN
  // One extra bit keeps the magnitude of the most negative value exact.
  logic [DataWidth:0] mag_a;
  logic [DataWidth:0] mag_b;

  always_comb begin
    mag_a = a_sel[DataWidth-1]
          ? (DataWidth+1)'(0) - {1'b1, a_sel}
          : {1'b0, a_sel};
    mag_b = b_sel[DataWidth-1]
          ? (DataWidth+1)'(0) - {1'b1, b_sel}
          : {1'b0, b_sel};
    mcand_init  = ProdW'(mag_a);
    mplier_init = mag_b;
    product     = neg_q ? ProdW'(0) - acc_q : acc_q;
  end
`else
  always_comb begin
    mcand_init  = ProdW'(a_sel);
    mplier_init = b_sel;
    product     = acc_q;
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = done_q;
    result_d = result_q;
    rr_d     = rr_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef SHIFT_MULT_SIGNED_EN
    neg_d    = neg_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = NumClients'(1) << pick_idx;
          rr_d    = pick_idx;
          state_d = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (!req_g) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (start_g) begin
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = mcand_init;
          mplier_d = mplier_init;
`ifdef SHIFT_MULT_SIGNED_EN
          neg_d    = a_sel[DataWidth-1] ^ b_sel[DataWidth-1];
`endif
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (!req_g) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CntW'(DataWidth)) begin
          result_d = product;
          done_d   = grant_q;
          state_d  = ST_DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!req_g) begin
          done_d  = '0;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      rr_q     <= ClientIdxWidth'(NumClients - 1);
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef SHIFT_MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      rr_q     <= rr_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef SHIFT_MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign bus.grant_o  = grant_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.busy_o   = (state_q == ST_CALC);

endmodule

// File: tb/tb_shift_mult_server.sv
// Bench for shift_mult_server: directed and random transactions
// against a plain-arithmetic product and round-robin model.
module tb_shift_mult_server;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  shift_mult_if #(.NumClients(N), .DataWidth(W)) bus ();

  shift_mult_server #(.NumClients(N), .DataWidth(W)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int last = N - 1;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int p;
`ifdef SHIFT_MULT_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return p[2*W-1:0];
  endfunction

  function automatic int rr_next(input logic [N-1:0] req, input int prev);
    for (int i = 1; i <= N; i++) begin
      if (req[(prev + i) % N]) return (prev + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    return N'(1) << k;
  endfunction

  task automatic set_ops(input logic [1:0] k, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    op_a[k] = a;
    op_b[k] = b;
    bus.a_i = {op_a[3], op_a[2], op_a[1], op_a[0]};
    bus.b_i = {op_b[3], op_b[2], op_b[1], op_b[0]};
  endtask

  task automatic wait_done(input logic [1:0] k, input string tag,
                           output int n);
    n = 0;
    while (bus.done_o == '0 && n < 40) begin
      check({tag, "_onehot"}, 32'($countones(bus.grant_o) <= 1), 32'd1);
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(bus.done_o), 32'(onehot(k)));
    check({tag, "_result"}, 32'(bus.result_o),
          32'(ref_mul(op_a[k], op_b[k])));
  endtask

  task automatic serve(input logic [1:0] k, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string tag);
    int n;
    logic [2*W-1:0] r;
    set_ops(k, a, b);
    bus.req_i[k] = 1'b1;
    bus.start_i[k] = 1'b1;
    @(negedge clk);
    check({tag, "_grant"}, 32'(bus.grant_o),
          32'(onehot(rr_next(onehot(k), last))));
    last = k;
    @(negedge clk);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
    wait_done(k, tag, n);
    check({tag, "_latency"}, 32'(n), 32'(W + 1));
    r = ref_mul(a, b);
    @(negedge clk);
    check({tag, "_hold_done"}, 32'(bus.done_o), 32'(onehot(k)));
    check({tag, "_hold_res"}, 32'(bus.result_o), 32'(r));
    bus.req_i[k] = 1'b0;
    bus.start_i[k] = 1'b0;
    @(negedge clk);
    check({tag, "_rel_grant"}, 32'(bus.grant_o), 32'd0);
    check({tag, "_rel_done"}, 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    int n;
    int exp_k;
    logic [1:0] k;
    bus.req_i = '0;
    bus.start_i = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    bus.a_i = '0;
    bus.b_i = '0;

    #12;
    check("rst_grant", 32'(bus.grant_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_result", 32'(bus.result_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    serve(2'd0, 8'd7, 8'd9, "c0_7x9");
    check("c0_7x9_is63", 32'(ref_mul(8'd7, 8'd9)), 32'd63);
    serve(2'd1, 8'hFF, 8'hFF, "ff_ff");
    serve(2'd2, 8'hFD, 8'd5, "neg3x5");
    serve(2'd3, 8'h80, 8'h80, "m128sq");
    serve(2'd1, 8'h00, 8'hA5, "zero_a");
    serve(2'd0, 8'h01, 8'hFF, "one_x");
    for (int i = 0; i < 12; i++) begin
      serve(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), "rand");
    end

    // All clients request and start continuously.
    for (int i = 0; i < N; i++) begin
      set_ops(2'(i), W'($urandom), W'($urandom));
    end
    bus.req_i = '1;
    bus.start_i = '1;
    exp_k = rr_next('1, last);
    @(negedge clk);
    for (int g = 0; g < 8; g++) begin
      k = 2'(exp_k);
      check("rr_grant", 32'(bus.grant_o), 32'(onehot(exp_k)));
      wait_done(k, "rr", n);
      check("rr_latency", 32'(n), 32'(W + 2));
      bus.req_i[k] = 1'b0;
      @(negedge clk);
      check("rr_idle", 32'(bus.grant_o), 32'd0);
      bus.req_i[k] = 1'b1;
      set_ops(k, W'($urandom), W'($urandom));
      last = exp_k;
      exp_k = rr_next('1, last);
      @(negedge clk);
    end
    bus.req_i = '0;
    bus.start_i = '0;
    @(negedge clk);
    @(negedge clk);
    // In-flight grant during the release wait may have been taken.
    last = rr_next('1, last);
    check("rr_quiet", 32'(bus.grant_o), 32'd0);

    // Client 2 aborts mid-calculation while client 3 waits.
    set_ops(2'd2, W'($urandom), W'($urandom));
    set_ops(2'd3, W'($urandom), W'($urandom));
    bus.req_i[2] = 1'b1;
    bus.start_i[2] = 1'b1;
    @(negedge clk);
    check("ab_grant2", 32'(bus.grant_o), 32'(onehot(2)));
    last = 2;
    bus.req_i[3] = 1'b1;
    bus.start_i[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ab_busy", 32'(bus.busy_o), 32'd1);
    end
    bus.req_i[2] = 1'b0;
    bus.start_i[2] = 1'b0;
    @(negedge clk);
    check("ab_busy0", 32'(bus.busy_o), 32'd0);
    check("ab_done0", 32'(bus.done_o), 32'd0);
    check("ab_grant0", 32'(bus.grant_o), 32'd0);
    @(negedge clk);
    check("ab_grant3", 32'(bus.grant_o),
          32'(onehot(rr_next(4'b1000, last))));
    last = 3;
    wait_done(2'd3, "ab_c3", n);
    check("ab_c3_latency", 32'(n), 32'(W + 2));
    bus.req_i[3] = 1'b0;
    bus.start_i[3] = 1'b0;
    @(negedge clk);
    check("ab_c3_rel", 32'(bus.grant_o), 32'd0);

    // Asynchronous reset in the middle of a calculation.
    set_ops(2'd0, 8'hC3, 8'h5A);
    bus.req_i[0] = 1'b1;
    bus.start_i[0] = 1'b1;
    @(negedge clk);
    check("rs_grant", 32'(bus.grant_o), 32'(onehot(0)));
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_grant0", 32'(bus.grant_o), 32'd0);
    check("rs_done0", 32'(bus.done_o), 32'd0);
    check("rs_busy0", 32'(bus.busy_o), 32'd0);
    check("rs_result0", 32'(bus.result_o), 32'd0);
    bus.req_i = '0;
    bus.start_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    last = N - 1;
    @(negedge clk);
    serve(2'd1, 8'd200, 8'd3, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_mult_server.md
Name: shift_mult_server

Overview:
- Shared sequential shift-add multiplier: the responder end of the multiplier mutex/handshake (req/grant, start/busy/done, operands/result) that convolution and neuron engines drive as initiators.
- Arbitrates up to NumClients requesters round-robin and grants the multiplier to one at a time.
- Captures the granted client's operands on start, computes the product over DataWidth cycles, and returns the result with a done indication.
- Sits between the compute engines and the single multiplier resource in each layer.

Parameters:
- NumClients, 4, number of requesting engines (>=1).
- DataWidth, 8, operand width; the result is 2*DataWidth.
- ClientIdxWidth, $clog2(NumClients) (minimum 1), width of the internal grant index.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- req_i  in  NumClients  per-client mutex request; level, held until the client has consumed done.
- grant_o  out  NumClients  one-hot mutex grant; at most one bit set.
- start_i  in  NumClients  per-client start; only meaningful while that client is granted.
- a_i  in  NumClients*DataWidth  packed operand A; client k uses bits [k*DataWidth +: DataWidth].
- b_i  in  NumClients*DataWidth  packed operand B, same packing as a_i.
- busy_o  out  1  high while in ST_CALC.
- done_o  out  NumClients  one-hot done for the granted client.
- result_o  out  2*DataWidth  product; valid while the corresponding done_o bit is high.

Behaviour:
- Reset (async assert, sync release): state=ST_IDLE; grant_o=0, done_o=0, busy_o=0, result_o=0; rr pointer=NumClients-1. Asserting reset mid-operation aborts immediately with no done.
- ST_IDLE:
  - If any req_i bit is set, pick the first set bit searching upward from rr+1, wrapping.
  - Register grant_o to that bit and rr to its index; go to ST_GRANTED.
  - Grant becomes visible the cycle after the request is sampled.
- ST_GRANTED:
  - If req_i[g]=0: clear grant; go to ST_IDLE.
  - Else if start_i[g]=1: capture a_i/b_i slice g; initialise accumulator=0 and bit counter=0; busy_o=1; go to ST_CALC.
  - start_i of non-granted clients is ignored in every state.
- ST_CALC:
  - One multiplier bit per cycle, LSB first: if the current multiplier bit is 1, add (multiplicand << counter) into the 2*DataWidth accumulator.
  - After DataWidth iterations, load result_o, set done_o[g]=1, busy_o=0; go to ST_DONE.
  - Latency: start sampled at cycle t gives done_o high at t+DataWidth+1.
  - If req_i[g] falls during ST_CALC: abort, discard the result, clear grant and busy, no done; go to ST_IDLE.
- ST_DONE:
  - done_o[g] and result_o are held until req_i[g]=0.
  - Then clear done_o and grant_o in the same cycle; go to ST_IDLE.
  - A new arbitration is possible in the following cycle, so back-to-back requests lose exactly one idle cycle.
- Fairness: the client just served has the lowest priority next round. With all clients requesting continuously, grants rotate 0,1,2,3,0...
- Simultaneous events:
  - A new req_i from another client during service is only registered in ST_IDLE.
  - req_i and start_i rising together at the same client: grant comes first, start is sampled in ST_GRANTED.
  - A client holding start_i high before grant is legal; start is honoured on the first granted cycle.
- Arithmetic: no overflow is possible; the product fits 2*DataWidth exactly.

Optional Feature:
- Macro SHIFT_MULT_SIGNED_EN.
- Defined: operands are two's complement.
  - Capture the magnitudes and the XOR of the sign bits.
  - Run the unsigned shift-add on the magnitudes; negate the result before loading result_o if the sign XOR=1.
  - Magnitude of -2^(DataWidth-1) is handled at DataWidth+1 bits internally. Latency is unchanged.
- Undefined: unsigned operands only; no sign logic is present.

Test Plan:
- Single client 0, a=7, b=9 (DataWidth=8) -> grant_o=0001 one cycle after req; done_o=0001 exactly 9 cycles after start sampled; result_o=63; done held until req drops, then grant_o=0000.
- All four clients requesting continuously, each starting immediately -> grant order 0,1,2,3,0; never more than one grant_o bit set; one idle cycle between grants.
- a=255, b=255 unsigned -> result_o=65025 (0xFE01).
- SHIFT_MULT_SIGNED_EN: a=-3 (0xFD), b=5 -> result_o=0xFFF1 (-15); a=-128, b=-128 -> result_o=0x4000.
- Client 2 drops req at iteration 4 of ST_CALC -> no done_o, busy_o=0 next cycle, client 3's pending request granted after returning to ST_IDLE.
- reset_ni asserted low mid-ST_CALC -> all outputs 0 asynchronously; after release, a fresh request completes with the correct product.
